// File: rtl/demux8_deser.sv
// Serial-to-parallel demux: fills eight output lanes one bit at a time, either
// sequentially (frame handshake on completion) or by direct lane address.
module demux8_deser (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       in_valid,
    input  logic       din,
    output logic       in_ready,
    input  logic       addr_mode,
    input  logic [2:0] Selector,
    output logic [7:0] q,
    output logic [2:0] ptr,
    output logic       out_valid,
    input  logic       out_ready
);

    typedef enum logic {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } state_t;

    state_t     state_reg, state_next;
    logic [7:0] q_reg, q_next;
    logic [2:0] ptr_reg, ptr_next;
    logic [7:0] lane_we;
    logic       accept;

    assign accept = in_valid && (state_reg == COLLECT) && !clear;

    // One write enable per lane; the lane is picked by Selector or by ptr.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_lane
            assign lane_we[gi] = accept &&
                                 (addr_mode ? (Selector == 3'(gi)) : (ptr_reg == 3'(gi)));
            assign q_next[gi]  = clear ? 1'b0 : (lane_we[gi] ? din : q_reg[gi]);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= COLLECT;
            q_reg     <= 8'h00;
            ptr_reg   <= 3'd0;
        end else begin
            state_reg <= state_next;
            q_reg     <= q_next;
            ptr_reg   <= ptr_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        in_ready   = (state_reg == COLLECT);
        out_valid  = (state_reg == FULL);
        if (clear) begin
            state_next = COLLECT;
            ptr_next   = 3'd0;
        end else begin
            case (state_reg)
                COLLECT: begin
                    // The 3-bit pointer wraps to 0 naturally on the eighth bit.
                    if (accept && !addr_mode) begin
                        ptr_next = ptr_reg + 3'd1;
                        if (ptr_reg == 3'd7) begin
                            state_next = FULL;
                        end
                    end
                end
                FULL: begin
                    if (out_ready) begin
                        state_next = COLLECT;
                    end
                end
                default: state_next = COLLECT;
            endcase
        end
    end

    assign q   = q_reg;
    assign ptr = ptr_reg;

endmodule

// File: tb/tb_demux8_deser.sv
// Directed bench for demux8_deser: a behavioural model predicts each cycle's
// outputs into a scoreboard queue, popped and compared after the clock edge.
module tb_demux8_deser;

    logic       clk;
    logic       rst_n;
    logic       clear;
    logic       in_valid;
    logic       din;
    logic       in_ready;
    logic       addr_mode;
    logic [2:0] Selector;
    logic [7:0] q;
    logic [2:0] ptr;
    logic       out_valid;
    logic       out_ready;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        string      tag;
        logic [7:0] q;
        logic [2:0] ptr;
        logic       out_valid;
        logic       in_ready;
    } exp_t;

    exp_t sb[$];

    logic [7:0] m_q;
    int         m_ptr;
    bit         m_full;

    demux8_deser dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .din       (din),
        .in_ready  (in_ready),
        .addr_mode (addr_mode),
        .Selector  (Selector),
        .q         (q),
        .ptr       (ptr),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q    = 8'h00;
        m_ptr  = 0;
        m_full = 1'b0;
    endtask

    // Drive one cycle, predict its result, clock, then pop and compare.
    task automatic step(input string tag, input bit iv, input bit d, input bit am,
                        input int sel, input bit ordy, input bit clr);
        exp_t e;
        in_valid  = iv;
        din       = d;
        addr_mode = am;
        Selector  = 3'(sel);
        out_ready = ordy;
        clear     = clr;
        if (clr) begin
            model_reset();
        end else if (!m_full) begin
            if (iv) begin
                if (am) begin
                    m_q[sel] = d;
                end else begin
                    m_q[m_ptr] = d;
                    if (m_ptr == 7) begin
                        m_ptr  = 0;
                        m_full = 1'b1;
                    end else begin
                        m_ptr = m_ptr + 1;
                    end
                end
            end
        end else if (ordy) begin
            m_full = 1'b0;
        end
        e.tag       = tag;
        e.q         = m_q;
        e.ptr       = 3'(m_ptr);
        e.out_valid = m_full;
        e.in_ready  = !m_full;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        $display("[TB] %s: iv=%0d din=%0d am=%0d sel=%0d ordy=%0d clr=%0d -> q=%h ptr=%0d ov=%0d ir=%0d",
                 tag, iv, d, am, sel, ordy, clr, q, ptr, out_valid, in_ready);
        chk({e.tag, ".q"}, q, e.q);
        chk({e.tag, ".ptr"}, {5'd0, ptr}, {5'd0, e.ptr});
        chk({e.tag, ".out_valid"}, {7'd0, out_valid}, {7'd0, e.out_valid});
        chk({e.tag, ".in_ready"}, {7'd0, in_ready}, {7'd0, e.in_ready});
        in_valid  = 1'b0;
        out_ready = 1'b0;
        clear     = 1'b0;
    endtask

    task automatic seq_bits(input string tag, input logic [7:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            step(tag, 1'b1, bits[i], 1'b0, 0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        din       = 1'b0;
        addr_mode = 1'b0;
        Selector  = 3'd0;
        out_ready = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst.q", q, 8'h00);
        chk("rst.ptr", {5'd0, ptr}, 8'd0);
        chk("rst.in_ready", {7'd0, in_ready}, 8'd1);
        chk("rst.out_valid", {7'd0, out_valid}, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Frame 1,0,1,1,0,0,1,0 -> 8'h4D
        seq_bits("s1", 8'b0100_1101, 8);
        chk("s1.frame", q, 8'h4D);
        chk("s1.ov", {7'd0, out_valid}, 8'd1);
        chk("s1.ir", {7'd0, in_ready}, 8'd0);
        chk("s1.ptr", {5'd0, ptr}, 8'd0);

        // Hold FULL while in_valid keeps pushing ones
        for (int i = 0; i < 5; i++) step("s2.hold", 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0);
        chk("s2.held", q, 8'h4D);
        step("s2.release", 1'b1, 1'b1, 1'b0, 0, 1'b1, 1'b0);
        chk("s2.ir", {7'd0, in_ready}, 8'd1);
        chk("s2.noacc", q, 8'h4D);
        chk("s2.ptr", {5'd0, ptr}, 8'd0);

        // Addressed writes from a cleared state
        step("s3.clr", 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1);
        step("s3.a5", 1'b1, 1'b1, 1'b1, 5, 1'b0, 1'b0);
        step("s3.a2", 1'b1, 1'b1, 1'b1, 2, 1'b0, 1'b0);
        chk("s3.q", q, 8'h24);
        chk("s3.ptr", {5'd0, ptr}, 8'd0);
        chk("s3.ov", {7'd0, out_valid}, 8'd0);

        // Clear beats a simultaneous in_valid
        step("s4.clr0", 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1);
        seq_bits("s4", 8'b0000_0111, 3);
        chk("s4.mid", q, 8'h07);
        step("s4.clr", 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b1);
        chk("s4.q", q, 8'h00);
        chk("s4.ptr", {5'd0, ptr}, 8'd0);

        // Async reset pulse mid-frame, then a fresh frame from lane 0
        seq_bits("s5.pre", 8'b0001_1111, 5);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("s5.rst_q", q, 8'h00);
        chk("s5.rst_ptr", {5'd0, ptr}, 8'd0);
        model_reset();
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        seq_bits("s5", 8'b1001_0110, 8);
        chk("s5.frame", q, 8'h96);
        chk("s5.ov", {7'd0, out_valid}, 8'd1);
        step("s5.release", 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0);

        // Mode switch mid-frame keeps ptr; last sequential bit lands in q[7]
        step("s6.clr", 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1);
        seq_bits("s6.a", 8'b0000_1111, 4);
        chk("s6.ptr4", {5'd0, ptr}, 8'd4);
        step("s6.addr7", 1'b1, 1'b1, 1'b1, 7, 1'b0, 1'b0);
        chk("s6.q8f", q, 8'h8F);
        chk("s6.ptrkeep", {5'd0, ptr}, 8'd4);
        seq_bits("s6.b", 8'b0000_0100, 4);
        chk("s6.frame", q, 8'h4F);
        chk("s6.ov", {7'd0, out_valid}, 8'd1);
        chk("s6.q7", {7'd0, q[7]}, 8'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
